// File: rtl/pixel_write_sink_pkg.sv
// Shared screen geometry, framebuffer sizing, FSM encoding and address helper
// for the pixel write sink.
package pixel_write_sink_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int FB_WORDS = 76800;
  localparam int ADDR_W   = 17;
  localparam int COLOR_W  = 12;
  localparam int ENTRY_W  = ADDR_W + COLOR_W;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  // y*320 + x built from two shifts and an add, so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [8:0] x, input logic [7:0] y);
    return {1'b0, y, 8'd0} + {3'b000, y, 6'd0} + {8'd0, x};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding {address, colour} entries between the
// accept stage and the framebuffer write port. Head is visible combinationally.
module pixel_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];
  assign w_push   = push & ~full;
  assign w_pop    = pop & ~empty;

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_sink.sv
// Pixel write sink: filters incoming (x, y, colour) writes, buffers them,
// writes them into the 320x240 framebuffer, and runs the full-frame clear.
module pixel_write_sink
  import pixel_write_sink_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter bit          KEY_EN      = 1'b1,
  parameter logic [11:0] KEY_COLOR   = 12'h000,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8:0]         in_x,
  input  logic [7:0]         in_y,
  input  logic [11:0]        in_color,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic               clear_done,
  input  logic               fb_ready,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic [ADDR_W-1:0]  written_count,
  output logic [7:0]         dropped_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                r_fb_we;
  logic [ADDR_W-1:0]   r_fb_addr;
  logic [COLOR_W-1:0]  r_fb_data;
  logic [ADDR_W-1:0]   r_written;
  logic [7:0]          r_dropped;

  logic                w_ready;
  logic                w_busy;
  logic                w_done;
  logic                w_clr_write;
  logic                w_clear_start;
  logic                w_accept;
  logic                w_drop;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CW-1:0]       w_count;
  logic [ENTRY_W-1:0]  w_head;

  // A pixel is consumed whenever the handshake completes; only on-screen,
  // non-key pixels are kept.
  assign w_accept = in_valid & w_ready;
  assign w_drop   = (in_x >= 9'(SCREEN_W)) || (in_y >= 8'(SCREEN_H)) ||
                    (KEY_EN && (in_color == KEY_COLOR));
  assign w_push   = w_accept & ~w_drop;
  assign w_pop    = ~w_fifo_empty & fb_ready;

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (w_push),
    .push_data ({pixel_addr(in_x, in_y), in_color}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= RUN;
    else         r_state <= w_state_next;
  end

  // Next-state and per-state control decode.
  always_comb begin
    w_state_next  = r_state;
    w_ready       = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_clr_write   = 1'b0;
    w_clear_start = 1'b0;
    case (r_state)
      RUN: begin
        // Registered count, so a same-cycle pop never lets a push overfill.
        w_ready = (w_count < CW'(DEPTH));
        if (clear_req) w_state_next = DRAIN;
      end
      DRAIN: begin
        w_busy = 1'b1;
        if (w_fifo_empty) begin
          w_state_next  = CLEAR;
          w_clear_start = 1'b1;
        end
      end
      CLEAR: begin
        w_busy = 1'b1;
        if (fb_ready) begin
          w_clr_write = 1'b1;
          if (r_clr_addr == ADDR_W'(FB_WORDS - 1)) w_state_next = DONE;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  // Framebuffer port: FIFO head or clear word; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      r_fb_we <= 1'b0;
      if (w_pop) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= w_head[ENTRY_W-1:COLOR_W];
        r_fb_data <= w_head[COLOR_W-1:0];
      end else if (w_clr_write) begin
        r_fb_we   <= 1'b1;
        r_fb_addr <= r_clr_addr;
        r_fb_data <= CLEAR_COLOR;
      end
    end
  end

  // Clear address sweep and wrapping write counter, both restarted at clear start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_clr_addr <= '0;
      r_written  <= '0;
    end else if (w_clear_start) begin
      r_clr_addr <= '0;
      r_written  <= '0;
    end else begin
      if (w_clr_write)          r_clr_addr <= r_clr_addr + 1'b1;
      if (w_pop || w_clr_write) r_written  <= r_written + 1'b1;
    end
  end

  // Saturating count of filtered-out pixels.
  always_ff @(posedge clk) begin
    if (!resetn)                                        r_dropped <= '0;
    else if (w_accept && w_drop && r_dropped != 8'hFF) r_dropped <= r_dropped + 1'b1;
  end

  assign in_ready      = w_ready;
  assign clear_busy    = w_busy;
  assign clear_done    = w_done;
  assign fb_we         = r_fb_we;
  assign fb_addr       = r_fb_addr;
  assign fb_data       = r_fb_data;
  assign written_count = r_written;
  assign dropped_count = r_dropped;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Scoreboard bench for pixel_write_sink: stimulus pushes expected framebuffer
// writes, a negedge monitor pops and compares every fb_we cycle.
module tb_pixel_write_sink;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_x;
  logic [7:0]  in_y;
  logic [11:0] in_color;
  logic        clear_req;
  logic        clear_busy;
  logic        clear_done;
  logic        fb_ready;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;
  logic [16:0] written_count;
  logic [7:0]  dropped_count;

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] data;
  } exp_t;

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] c;
    logic        drop;
    logic [16:0] addr;
  } vec_t;

  localparam vec_t VB [6] = '{
    '{9'd0,   8'd0,   12'hFFF, 1'b0, 17'd0},
    '{9'd319, 8'd239, 12'hABC, 1'b0, 17'd76799},
    '{9'd320, 8'd5,   12'h123, 1'b1, 17'd0},
    '{9'd10,  8'd240, 12'h123, 1'b1, 17'd0},
    '{9'd5,   8'd5,   12'h000, 1'b1, 17'd0},
    '{9'd5,   8'd5,   12'h001, 1'b0, 17'd1605}
  };

  localparam vec_t VP [6] = '{
    '{9'd10, 8'd1, 12'h101, 1'b0, 17'd330},
    '{9'd20, 8'd2, 12'h102, 1'b0, 17'd660},
    '{9'd30, 8'd3, 12'h103, 1'b0, 17'd990},
    '{9'd40, 8'd4, 12'h104, 1'b0, 17'd1320},
    '{9'd50, 8'd5, 12'h105, 1'b0, 17'd1650},
    '{9'd60, 8'd6, 12'h106, 1'b0, 17'd1980}
  };

  localparam vec_t VC [3] = '{
    '{9'd1, 8'd1, 12'h0AA, 1'b0, 17'd321},
    '{9'd2, 8'd0, 12'h0BB, 1'b0, 17'd2},
    '{9'd7, 8'd3, 12'h777, 1'b0, 17'd967}
  };

  exp_t sb_q [$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   exp_dropped  = 0;
  bit   verbose      = 1'b1;

  always #5 clk = ~clk;

  pixel_write_sink #(
    .DEPTH       (4),
    .KEY_EN      (1'b1),
    .KEY_COLOR   (12'h000),
    .CLEAR_COLOR (12'h000)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_color      (in_color),
    .clear_req     (clear_req),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .fb_ready      (fb_ready),
    .fb_we         (fb_we),
    .fb_addr       (fb_addr),
    .fb_data       (fb_data),
    .written_count (written_count),
    .dropped_count (dropped_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every framebuffer write must match the oldest expected write.
  always @(negedge clk) begin
    if (resetn && fb_we) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_write: got addr %0d data %03h, expected no write", fb_addr, fb_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wr_addr", 32'(fb_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(fb_data), 32'(mon_e.data));
        if (verbose) $display("[TB] write addr=%0d data=%03h", fb_addr, fb_data);
      end
    end
  end

  // Present one pixel (called just after a negedge), wait for in_ready, record
  // the expected outcome, and return at the negedge after the accepting edge.
  task automatic offer(input vec_t v);
    int k;
    in_x = v.x; in_y = v.y; in_color = v.c; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL offer_timeout: got in_ready 0 for 200 cycles, expected 1 (x=%0d y=%0d)", v.x, v.y);
      in_valid = 1'b0;
      return;
    end
    if (v.drop) exp_dropped++;
    else        sb_q.push_back({v.addr, v.c});
    $display("[TB] offer x=%0d y=%0d color=%03h %s", v.x, v.y, v.c, v.drop ? "drop" : "keep");
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready), 32'd1);
    chk({tag, "_fb_we"},      32'(fb_we), 32'd0);
    chk({tag, "_fb_addr"},    32'(fb_addr), 32'd0);
    chk({tag, "_fb_data"},    32'(fb_data), 32'd0);
    chk({tag, "_written"},    32'(written_count), 32'd0);
    chk({tag, "_dropped"},    32'(dropped_count), 32'd0);
    chk({tag, "_clear_busy"}, 32'(clear_busy), 32'd0);
    chk({tag, "_clear_done"}, 32'(clear_done), 32'd0);
  endtask

  initial begin
    int k;
    resetn = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_color = '0;
    clear_req = 1'b0; fb_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b1; fb_ready = 1'b1;
    @(negedge clk);

    // First pixel: one-cycle latency from accept to write.
    offer(VB[0]);
    in_valid = 1'b0;
    chk("latency_we_early", 32'(fb_we), 32'd0);
    @(negedge clk);
    chk("first_we", 32'(fb_we), 32'd1);
    chk("first_written", 32'(written_count), 32'd1);

    // Corner pixel and two off-screen drops; address holds after the drops.
    offer(VB[1]); offer(VB[2]); offer(VB[3]);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("offscreen_dropped", 32'(dropped_count), 32'(exp_dropped));
    chk("offscreen_written", 32'(written_count), 32'd2);
    chk("hold_addr", 32'(fb_addr), 32'd76799);
    chk("hold_we", 32'(fb_we), 32'd0);

    // Colour key drop, then a near-key colour that must be written.
    offer(VB[4]); offer(VB[5]);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("key_dropped", 32'(dropped_count), 32'(exp_dropped));
    chk("key_written", 32'(written_count), 32'd3);

    // Backpressure: four fill the FIFO, the fifth waits with in_ready low.
    fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(VP[i]);
    in_x = VP[4].x; in_y = VP[4].y; in_color = VP[4].c; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("stall_we", 32'(fb_we), 32'd0);
      @(negedge clk);
    end
    chk("stall_written", 32'(written_count), 32'd3);
    fb_ready = 1'b1;
    offer(VP[4]); offer(VP[5]);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("bp_written", 32'(written_count), 32'd9);
    chk("bp_queue_empty", 32'(sb_q.size()), 32'd0);

    // Clear with two pixels buffered: drain first, then the full sweep.
    fb_ready = 1'b0;
    offer(VC[0]); offer(VC[1]);
    in_valid = 1'b0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("clear_busy_start", 32'(clear_busy), 32'd1);
    chk("clear_in_ready", 32'(in_ready), 32'd0);
    for (int a = 0; a < 76800; a++) sb_q.push_back({17'(a), 12'h000});
    $display("[TB] clear requested, expecting 2 drain writes and 76800 clear writes");
    verbose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      fb_ready = (i % 2 == 1);
      @(negedge clk);
    end
    fb_ready = 1'b1;
    k = 0;
    while (!clear_done && k < 80000) begin
      @(negedge clk);
      k++;
    end
    chk("clear_done_seen", 32'(clear_done), 32'd1);
    chk("done_busy", 32'(clear_busy), 32'd0);
    @(negedge clk);
    chk("done_pulse_width", 32'(clear_done), 32'd0);
    chk("after_clear_ready", 32'(in_ready), 32'd1);
    chk("after_clear_written", 32'(written_count), 32'd76800);
    chk("after_clear_addr", 32'(fb_addr), 32'd76799);
    chk("clear_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] clear complete");

    // Reset in the middle of a clear sweep: no done pulse, back to RUN.
    for (int a = 0; a < 200; a++) sb_q.push_back({17'(a), 12'h000});
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (40) @(negedge clk);
    chk("midclear_busy", 32'(clear_busy), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midclear_reset");
    @(negedge clk);
    chk("midclear_no_done", 32'(clear_done), 32'd0);
    sb_q.delete();
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_no_done", 32'(clear_done), 32'd0);
    $display("[TB] reset during clear applied");
    verbose = 1'b1;

    // Normal operation resumes after the aborted clear.
    offer(VC[2]);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("resume_written", 32'(written_count), 32'd1);
    chk("resume_addr", 32'(fb_addr), 32'd967);
    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
